// File: rtl/speed_dash_sequencer.sv
// Speed-cluster dash sequencer: converts a target speed into a dash count by
// scanning the threshold table, then ramps the lit dashes one step per STEP_DIV frames.
module speed_dash_sequencer #(
    parameter int unsigned STEP_DIV = 32'd1
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_animate,
    input  logic        i_speed_valid,
    input  logic [6:0]  i_speed,
    output logic        o_speed_ready,
    output logic [32:0] o_dash_en,
    output logic [5:0]  o_lit_count,
    output logic        o_busy,
    output logic        o_done
);

    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_CALC      = 2'd1,
        S_RAMP_UP   = 2'd2,
        S_RAMP_DOWN = 2'd3
    } state_t;

    localparam logic [5:0] MAX_DASH = 6'd33;
    localparam logic [3:0] DIV_MAX  = 4'(STEP_DIV - 32'd1);

    // Threshold in mph for dash k: 5 + 10*(k/4) + {0,2,5,8}[k%4].
    function automatic logic [6:0] dash_thr(input logic [5:0] k);
        logic [6:0] off;
        case (k[1:0])
            2'd0:    off = 7'd0;
            2'd1:    off = 7'd2;
            2'd2:    off = 7'd5;
            2'd3:    off = 7'd8;
            default: off = 7'd0;
        endcase
        return 7'd5 + (7'd10 * {3'd0, k[5:2]}) + off;
    endfunction

    state_t      state_q, state_d;
    logic [5:0]  lit_q, lit_d;
    logic [5:0]  target_q, target_d;
    logic [5:0]  k_q, k_d;
    logic [3:0]  div_q, div_d;
    logic [6:0]  speed_q, speed_d;
    logic        done_q, done_d;
    logic        calc_done_s;
    logic        accept_s;
    logic [5:0]  step_lit_s;
    logic [32:0] dash_en_s;

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= S_IDLE;
            lit_q    <= 6'd0;
            target_q <= 6'd0;
            k_q      <= 6'd0;
            div_q    <= 4'd0;
            speed_q  <= 7'd0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            lit_q    <= lit_d;
            target_q <= target_d;
            k_q      <= k_d;
            div_q    <= div_d;
            speed_q  <= speed_d;
            done_q   <= done_d;
        end
    end

    assign accept_s = i_speed_valid && (state_q != S_CALC);

    // Next-state logic; a new request outranks any same-cycle ramp step.
    always_comb begin
        state_d     = state_q;
        lit_d       = lit_q;
        target_d    = target_q;
        k_d         = k_q;
        div_d       = div_q;
        speed_d     = speed_q;
        done_d      = 1'b0;
        calc_done_s = 1'b0;
        step_lit_s  = lit_q;
        case (state_q)
            S_IDLE: begin
                if (accept_s) begin
                    speed_d = i_speed;
                    k_d     = 6'd0;
                    state_d = S_CALC;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CALC: begin
                if ((k_q == MAX_DASH) || (speed_q < dash_thr(k_q))) begin
                    target_d = k_q;
                    if (k_q > lit_q) begin
                        state_d = S_RAMP_UP;
                        div_d   = 4'd0;
                    end else if (k_q < lit_q) begin
                        state_d = S_RAMP_DOWN;
                        div_d   = 4'd0;
                    end else begin
                        state_d     = S_IDLE;
                        calc_done_s = 1'b1;
                    end
                end else begin
                    k_d = k_q + 6'd1;
                end
            end
            S_RAMP_UP, S_RAMP_DOWN: begin
                if (accept_s) begin
                    speed_d = i_speed;
                    k_d     = 6'd0;
                    state_d = S_CALC;
                end else if (i_animate) begin
                    if (div_q == DIV_MAX) begin
                        div_d = 4'd0;
                        if ((state_q == S_RAMP_UP) && (lit_q != MAX_DASH)) begin
                            step_lit_s = lit_q + 6'd1;
                        end else if ((state_q == S_RAMP_DOWN) && (lit_q != 6'd0)) begin
                            step_lit_s = lit_q - 6'd1;
                        end else begin
                            step_lit_s = lit_q;
                        end
                        lit_d = step_lit_s;
                        if (step_lit_s == target_q) begin
                            state_d = S_IDLE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        div_d = div_q + 4'd1;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Thermometer decode of the lit register.
    always_comb begin
        dash_en_s = 33'd0;
        for (int i = 0; i < 33; i++) begin
            dash_en_s[i] = (6'(i) < lit_q);
        end
    end

    assign o_dash_en     = dash_en_s;
    assign o_lit_count   = lit_q;
    assign o_busy        = (state_q != S_IDLE);
    assign o_speed_ready = (state_q != S_CALC);
    assign o_done        = done_q | calc_done_s;

endmodule

// File: tb/tb_speed_dash_sequencer.sv
// Bench for speed_dash_sequencer: two instances (STEP_DIV 1 and 3) driven with directed
// and random speed requests, checked against a threshold-count / pulse-count model.
module tb_speed_dash_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        anim [2];
    logic        vld  [2];
    logic [6:0]  spd  [2];
    logic        rdy  [2];
    logic [32:0] dash [2];
    logic [5:0]  lit  [2];
    logic        busy [2];
    logic        done [2];

    int checks = 0;
    int errors = 0;
    int m_lit [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        speed_dash_sequencer #(.STEP_DIV((g == 0) ? 1 : 3)) u_dut (
            .i_clk         (clk),
            .i_rst_n       (rst_n),
            .i_animate     (anim[g]),
            .i_speed_valid (vld[g]),
            .i_speed       (spd[g]),
            .o_speed_ready (rdy[g]),
            .o_dash_en     (dash[g]),
            .o_lit_count   (lit[g]),
            .o_busy        (busy[g]),
            .o_done        (done[g])
        );
    end

    function automatic int sd(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic int thr(input int k);
        int off;
        off = (k % 4 == 0) ? 0 : (k % 4 == 1) ? 2 : (k % 4 == 2) ? 5 : 8;
        return 5 + 10 * (k / 4) + off;
    endfunction

    // Target = how many dash thresholds the speed reaches.
    function automatic int tgt(input int s);
        int n = 0;
        for (int k = 0; k < 33; k++) begin
            if (s >= thr(k)) n++;
        end
        return n;
    endfunction

    function automatic logic [32:0] thermo(input int n);
        logic [32:0] v;
        v = '0;
        for (int i = 0; i < 33; i++) v[i] = (i < n);
        return v;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        for (int g = 0; g < 2; g++) begin
            anim[g] = 1'b0; vld[g] = 1'b0; spd[g] = 7'd0; m_lit[g] = 0;
        end
        repeat (2) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_calc(input int g, input int t);
        int n = 0;
        int dones = 0;
        bit exp_busy;
        while (rdy[g] == 1'b0 && n < 60) begin
            n++;
            if (done[g] === 1'b1) dones++;
            tick();
        end
        exp_busy = (t != m_lit[g]);
        checks++;
        if (n != t + 1) begin
            errors++; $display("FAIL calc_len[%0d]: got %0d cycles, expected %0d", g, n, t + 1);
        end
        checks++;
        if (lit[g] !== 6'(m_lit[g])) begin
            errors++; $display("FAIL calc_lit[%0d]: got %0d, expected %0d", g, lit[g], m_lit[g]);
        end
        checks++;
        if (busy[g] !== exp_busy) begin
            errors++; $display("FAIL calc_exit_busy[%0d]: got %b, expected %b", g, busy[g], exp_busy);
        end
        checks++;
        if (dones != (exp_busy ? 0 : 1)) begin
            errors++; $display("FAIL calc_done[%0d]: got %0d pulses, expected %0d", g, dones, exp_busy ? 0 : 1);
        end
    endtask

    task automatic request(input int g, input int s);
        checks++;
        if (rdy[g] !== 1'b1) begin
            errors++; $display("FAIL req_ready[%0d]: got %b, expected 1", g, rdy[g]);
        end
        vld[g] = 1'b1;
        spd[g] = 7'(s);
        tick();
        vld[g] = 1'b0;
        spd[g] = 7'($urandom);
        wait_calc(g, tgt(s));
    endtask

    task automatic ramp(input int g, input int t);
        int pulses = 0;
        int cyc = 0;
        int dones = 0;
        int dir;
        int exp_lit;
        int want;
        dir = (t > m_lit[g]) ? 1 : -1;
        while (busy[g] === 1'b1 && cyc < 3000) begin
            anim[g] = 1'($urandom_range(0, 1));
            if (anim[g]) pulses++;
            tick();
            anim[g] = 1'b0;
            cyc++;
            exp_lit = m_lit[g] + dir * (pulses / sd(g));
            checks++;
            if (lit[g] !== 6'(exp_lit)) begin
                errors++; $display("FAIL ramp_lit[%0d]: got %0d, expected %0d", g, lit[g], exp_lit);
            end
            if (done[g] === 1'b1) dones++;
        end
        want = ((t > m_lit[g]) ? (t - m_lit[g]) : (m_lit[g] - t)) * sd(g);
        checks++;
        if (cyc >= 3000) begin
            errors++; $display("FAIL ramp_timeout[%0d]: got %0d cycles, expected < 3000", g, cyc);
        end
        checks++;
        if (pulses != want) begin
            errors++; $display("FAIL ramp_pulses[%0d]: got %0d, expected %0d", g, pulses, want);
        end
        checks++;
        if (dones != 1 || done[g] !== 1'b1) begin
            errors++; $display("FAIL ramp_done[%0d]: got %0d pulses (last %b), expected 1 at IDLE entry", g, dones, done[g]);
        end
        checks++;
        if (dash[g] !== thermo(t) || lit[g] !== 6'(t)) begin
            errors++; $display("FAIL ramp_final[%0d]: got dash %h lit %0d, expected dash %h lit %0d", g, dash[g], lit[g], thermo(t), t);
        end
        m_lit[g] = t;
        tick();
        checks++;
        if (done[g] !== 1'b0) begin
            errors++; $display("FAIL done_width[%0d]: got %b, expected 0", g, done[g]);
        end
    endtask

    task automatic do_txn(input int g, input int s);
        int t;
        t = tgt(s);
        request(g, s);
        if (t != m_lit[g]) ramp(g, t);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #2;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (dash[g] !== 33'd0 || lit[g] !== 6'd0 || busy[g] !== 1'b0 || done[g] !== 1'b0 || rdy[g] !== 1'b1) begin
                errors++; $display("FAIL reset_outputs[%0d]: got dash %h lit %0d busy %b done %b rdy %b, expected 0 0 0 0 1",
                                   g, dash[g], lit[g], busy[g], done[g], rdy[g]);
            end
        end
        apply_reset();
    endtask

    task automatic test_directed();
        do_txn(0, 20);
        do_txn(0, 127);
        do_txn(0, 12);
        do_txn(0, 4);
        do_txn(0, 0);
        do_txn(0, 5);
        do_txn(0, 84);
        do_txn(0, 85);
        for (int i = 0; i < 4; i++) begin
            anim[0] = 1'b1;
            tick();
        end
        anim[0] = 1'b0;
        checks++;
        if (lit[0] !== 6'(m_lit[0]) || busy[0] !== 1'b0) begin
            errors++; $display("FAIL idle_animate: got lit %0d busy %b, expected %0d 0", lit[0], busy[0], m_lit[0]);
        end
        do_txn(1, 20);
        do_txn(1, 6);
    endtask

    task automatic test_random();
        for (int i = 0; i < 16; i++) begin
            int g;
            int s;
            g = i % 2;
            s = (i % 5 == 4) ? int'($urandom_range(85, 127)) : int'($urandom_range(0, 90));
            do_txn(g, s);
        end
    endtask

    task automatic test_priority();
        apply_reset();
        request(0, 27);
        for (int i = 0; i < 3; i++) begin
            anim[0] = 1'b1;
            tick();
        end
        anim[0] = 1'b1;
        vld[0]  = 1'b1;
        spd[0]  = 7'd7;
        tick();
        anim[0] = 1'b0;
        vld[0]  = 1'b0;
        checks++;
        if (lit[0] !== 6'd3 || rdy[0] !== 1'b0) begin
            errors++; $display("FAIL priority: got lit %0d rdy %b, expected 3 0", lit[0], rdy[0]);
        end
        m_lit[0] = 3;
        wait_calc(0, 2);
        ramp(0, 2);
    endtask

    task automatic test_reset_mid();
        int cyc = 0;
        apply_reset();
        request(1, 127);
        while (lit[1] !== 6'd5 && cyc < 200) begin
            anim[1] = 1'b1;
            tick();
            cyc++;
        end
        anim[1] = 1'b0;
        checks++;
        if (lit[1] !== 6'd5 || busy[1] !== 1'b1 || cyc != 15) begin
            errors++; $display("FAIL reach_lit5: got lit %0d busy %b after %0d pulses, expected 5 1 15", lit[1], busy[1], cyc);
        end
        vld[0] = 1'b1;
        spd[0] = 7'd127;
        tick();
        vld[0] = 1'b0;
        tick();
        #3 rst_n = 1'b0;
        #1;
        for (int g = 0; g < 2; g++) begin
            checks++;
            if (dash[g] !== 33'd0 || lit[g] !== 6'd0 || busy[g] !== 1'b0 || done[g] !== 1'b0 || rdy[g] !== 1'b1) begin
                errors++; $display("FAIL reset_mid[%0d]: got dash %h lit %0d busy %b done %b rdy %b, expected 0 0 0 0 1",
                                   g, dash[g], lit[g], busy[g], done[g], rdy[g]);
            end
        end
        apply_reset();
        do_txn(1, 10);
    endtask

    initial begin
        rst_n = 1'b1;
        for (int g = 0; g < 2; g++) begin
            anim[g] = 1'b0; vld[g] = 1'b0; spd[g] = 7'd0; m_lit[g] = 0;
        end
        #2;
        test_reset();
        test_directed();
        test_random();
        test_priority();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
